// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the rv32i memory arbiter
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        rv32i_word  address;
        rv32i_word  wdata;
        logic [3:0] wmask;
        mem_op_t    op;
    } mem_req_t;

    localparam mem_req_t REQ_RESET = '{address: '0, wdata: '0, wmask: '0, op: OP_READ};

endpackage

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - saturating wait counter for a memory transaction
module arb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    // Zero disables the timeout; keep a one-bit counter so the width never collapses.
    localparam int            W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0]  LIMIT = W'(TIMEOUT);

    logic [W-1:0] r_count;

    // Count waiting cycles, holding at the limit so expiry stays asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (r_count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data two-port to single memory port arbiter
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_a,
    input  rv32i_word   address_a,
    output logic        resp_a,
    output rv32i_word   rdata_a,
    input  logic        read_b,
    input  logic        write_b,
    input  rv32i_word   address_b,
    input  rv32i_word   wdata_b,
    input  logic [3:0]  wmask_b,
    output logic        resp_b,
    output rv32i_word   rdata_b,
    output logic        pmem_read,
    output logic        pmem_write,
    output rv32i_word   pmem_address,
    output rv32i_word   pmem_wdata,
    output logic [3:0]  pmem_wmask,
    input  rv32i_word   pmem_rdata,
    input  logic        pmem_resp,
    output logic        timeout_err
);

    arb_state_t r_state;
    arb_state_t w_next;
    mem_req_t   r_req;
    logic       r_last_b;

    logic w_req_a;
    logic w_req_b;
    logic w_grant_a;
    logic w_grant_b;
    logic w_serving;
    logic w_expired;
    logic w_finish;

    assign w_req_a   = read_a;
    assign w_req_b   = read_b | write_b;
    assign w_serving = (r_state != IDLE);
    // A real response in the expiry cycle wins over the timeout.
    assign w_finish  = w_serving && (pmem_resp || w_expired);

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!w_serving),
        .enable  (w_serving && !pmem_resp),
        .expired (w_expired)
    );

    // Grant selection in IDLE and return to IDLE once a transaction finishes.
    always_comb begin
        w_next    = r_state;
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_a && w_req_b) begin
                    w_grant_a = r_last_b;
                    w_grant_b = !r_last_b;
                end else begin
                    w_grant_a = w_req_a;
                    w_grant_b = w_req_b;
                end
                if (w_grant_a) begin
                    w_next = SERVE_A;
                end else if (w_grant_b) begin
                    w_next = SERVE_B;
                end
            end
            SERVE_A, SERVE_B: begin
                if (w_finish) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register, operand latches and fairness history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_req    <= REQ_RESET;
            r_last_b <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant_a) begin
                r_req <= '{address: address_a, wdata: '0, wmask: '0, op: OP_READ};
            end else if (w_grant_b) begin
                // A simultaneous read and write is treated as a write.
                r_req <= '{address: address_b, wdata: wdata_b, wmask: wmask_b,
                           op: (write_b ? OP_WRITE : OP_READ)};
            end
            if (w_finish) begin
                r_last_b <= (r_state == SERVE_B);
            end
        end
    end

    assign pmem_read    = w_serving && (r_req.op == OP_READ);
    assign pmem_write   = w_serving && (r_req.op == OP_WRITE);
    assign pmem_address = r_req.address;
    assign pmem_wdata   = r_req.wdata;
    assign pmem_wmask   = r_req.wmask;

    assign resp_a      = (r_state == SERVE_A) && pmem_resp;
    assign resp_b      = (r_state == SERVE_B) && pmem_resp;
    assign rdata_a     = resp_a ? pmem_rdata : '0;
    assign rdata_b     = resp_b ? pmem_rdata : '0;
    assign timeout_err = w_serving && w_expired && !pmem_resp;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        read_a;
    logic [31:0] address_a;
    logic        resp_a;
    logic [31:0] rdata_a;
    logic        read_b;
    logic        write_b;
    logic [31:0] address_b;
    logic [31:0] wdata_b;
    logic [3:0]  wmask_b;
    logic        resp_b;
    logic [31:0] rdata_b;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_wmask;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;
    logic        timeout_err;

    int n_checks;
    int n_fail;

    mem_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_a       (read_a),
        .address_a    (address_a),
        .resp_a       (resp_a),
        .rdata_a      (rdata_a),
        .read_b       (read_b),
        .write_b      (write_b),
        .address_b    (address_b),
        .wdata_b      (wdata_b),
        .wmask_b      (wmask_b),
        .resp_b       (resp_b),
        .rdata_b      (rdata_b),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_wmask   (pmem_wmask),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tie_addr [4];
    logic        tie_is_b [4];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        read_a     = 1'b0;
        address_a  = 32'h0;
        read_b     = 1'b0;
        write_b    = 1'b0;
        address_b  = 32'h0;
        wdata_b    = 32'h0;
        wmask_b    = 4'h0;
        pmem_rdata = 32'h0;
        pmem_resp  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_pmem_read",  {31'b0, pmem_read},  32'h0);
        check("rst_pmem_write", {31'b0, pmem_write}, 32'h0);
        check("rst_pmem_addr",  pmem_address,        32'h0);
        check("rst_resp",       {30'b0, resp_a, resp_b}, 32'h0);
        check("rst_timeout",    {31'b0, timeout_err}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single read on port A, latency 3
        read_a    = 1'b1;
        address_a = 32'h0000_0060;
        tick();
        check("rdA_strobe",   {31'b0, pmem_read},  32'h1);
        check("rdA_nowrite",  {31'b0, pmem_write}, 32'h0);
        check("rdA_addr",     pmem_address,        32'h60);
        check("rdA_noresp",   {31'b0, resp_a},     32'h0);
        tick();
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h0000_0013;
        #1;
        check("rdA_resp",     {31'b0, resp_a}, 32'h1);
        check("rdA_rdata",    rdata_a,         32'h13);
        check("rdA_respb",    {31'b0, resp_b}, 32'h0);
        check("rdA_rdatab",   rdata_b,         32'h0);
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = 32'h0;
        read_a     = 1'b0;
        #1;
        check("rdA_idle",     {31'b0, pmem_read}, 32'h0);
        check("rdA_onepulse", {31'b0, resp_a},    32'h0);
        tick();

        // Write on port B, latency 2
        write_b   = 1'b1;
        address_b = 32'h0000_0100;
        wdata_b   = 32'hDEAD_BEEF;
        wmask_b   = 4'h3;
        tick();
        check("wrB_strobe", {31'b0, pmem_write}, 32'h1);
        check("wrB_noread", {31'b0, pmem_read},  32'h0);
        check("wrB_addr",   pmem_address,        32'h100);
        check("wrB_wdata",  pmem_wdata,          32'hDEAD_BEEF);
        check("wrB_wmask",  {28'b0, pmem_wmask}, 32'h3);
        tick();
        pmem_resp = 1'b1;
        #1;
        check("wrB_resp",   {31'b0, resp_b}, 32'h1);
        check("wrB_rdata",  rdata_b,         32'h0);
        check("wrB_respa",  {31'b0, resp_a}, 32'h0);
        tick();
        pmem_resp = 1'b0;
        write_b   = 1'b0;
        wdata_b   = 32'h0;
        wmask_b   = 4'h0;
        tick();

        // Tie after a fresh reset: B, A, B, A with an IDLE gap between grants
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        address_a = 32'h0000_0040;
        address_b = 32'h0000_0080;
        tie_addr[0] = 32'h80; tie_is_b[0] = 1'b1;
        tie_addr[1] = 32'h40; tie_is_b[1] = 1'b0;
        tie_addr[2] = 32'h80; tie_is_b[2] = 1'b1;
        tie_addr[3] = 32'h40; tie_is_b[3] = 1'b0;
        tick();
        read_a = 1'b1;
        read_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("tie%0d_addr", i), pmem_address, tie_addr[i]);
            check($sformatf("tie%0d_strobe", i), {31'b0, pmem_read}, 32'h1);
            pmem_resp  = 1'b1;
            pmem_rdata = 32'h1000 + 32'(i);
            #1;
            check($sformatf("tie%0d_resp", i), {30'b0, resp_a, resp_b},
                  tie_is_b[i] ? 32'h1 : 32'h2);
            tick();
            pmem_resp = 1'b0;
            if (i == 3) begin
                read_a = 1'b0;
                read_b = 1'b0;
            end
            #1;
            check($sformatf("tie%0d_gap", i), {31'b0, pmem_read}, 32'h0);
        end

        // Request dropped and address changed mid-transaction
        read_a    = 1'b1;
        address_a = 32'h0000_0300;
        tick();
        check("drop_addr0", pmem_address, 32'h300);
        read_a    = 1'b0;
        address_a = 32'h0000_0200;
        tick();
        check("drop_addr1",   pmem_address,        32'h300);
        check("drop_strobe",  {31'b0, pmem_read},  32'h1);
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h0000_0077;
        #1;
        check("drop_resp",    {31'b0, resp_a}, 32'h1);
        check("drop_rdata",   rdata_a,         32'h77);
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = 32'h0;
        tick();

        // Timeout on port B with no memory response
        read_b    = 1'b1;
        address_b = 32'h0000_0080;
        tick();
        check("to_strobe", {31'b0, pmem_read}, 32'h1);
        tick();
        tick();
        tick();
        check("to_early", {31'b0, timeout_err}, 32'h0);
        tick();
        check("to_err",    {31'b0, timeout_err}, 32'h1);
        check("to_noresp", {30'b0, resp_a, resp_b}, 32'h0);
        read_a    = 1'b1;
        address_a = 32'h0000_0040;
        tick();
        check("to_drop",   {31'b0, pmem_read},   32'h0);
        check("to_pulse",  {31'b0, timeout_err}, 32'h0);
        tick();
        check("to_next_tie", pmem_address, 32'h40);
        pmem_resp = 1'b1;
        #1;
        check("to_next_resp", {30'b0, resp_a, resp_b}, 32'h2);
        tick();
        pmem_resp = 1'b0;
        read_a    = 1'b0;
        read_b    = 1'b0;
        tick();

        // Reset in the middle of a port B write
        write_b   = 1'b1;
        address_b = 32'h0000_0100;
        wdata_b   = 32'hCAFE_F00D;
        wmask_b   = 4'hF;
        tick();
        check("rmid_strobe", {31'b0, pmem_write}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rmid_write", {31'b0, pmem_write}, 32'h0);
        check("rmid_addr",  pmem_address,        32'h0);
        check("rmid_wdata", pmem_wdata,          32'h0);
        write_b   = 1'b0;
        address_b = 32'h0000_0080;
        tick();
        rst_n     = 1'b1;
        pmem_resp = 1'b1;
        #1;
        check("rmid_late", {29'b0, resp_a, resp_b, timeout_err}, 32'h0);
        tick();
        pmem_resp = 1'b0;
        read_a    = 1'b1;
        read_b    = 1'b1;
        tick();
        check("rmid_tie", pmem_address, 32'h80);
        pmem_resp = 1'b1;
        #1;
        check("rmid_tie_resp", {30'b0, resp_a, resp_b}, 32'h1);
        tick();
        pmem_resp = 1'b0;
        read_a    = 1'b0;
        read_b    = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
